easyaxi_rd_mst: RTL and testbench
=================================

# easyaxi_rd_mst

Parametrised AXI read master that accepts read commands on a valid/ready command port and issues them as AR bursts. It keeps up to OST_DEPTH transactions outstanding, one per tracking slot, with the ARID taken from the slot index. R beats are forwarded as a data stream tagged with the slot index. Per-transaction completion status (merged RRESP, length check) is returned in command order. It replaces the fixed-pattern test master as the reusable read engine for EasyAXI benches and DMA-style blocks.

## Interface
- OST_DEPTH, 8: tracking slots / max outstanding transactions; power of 2, 1..32
- ID_W, `AXI_ID_W: ARID/RID width; must be ≥ max(1, log2(OST_DEPTH))
- ADDR_W, `AXI_ADDR_W: address width
- DATA_W, `AXI_DATA_W: data width
- LEN_W, `AXI_LEN_W: ARLEN width (8 → up to 256 beats)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_addr / cmd_len / cmd_size / cmd_burst  in  ADDR_W / LEN_W / `AXI_SIZE_W / `AXI_BURST_W  burst descriptor
- axi_mst_ar{valid,ready,id,addr,len,size,burst}  out/in/out…  AXI AR channel
- axi_mst_r{valid,ready,id,data,resp,last}  in/out/in…  AXI R channel
- dat_valid  out  1  one-cycle pulse per accepted R beat
- dat_slot / dat_data / dat_last  out  log2(OST_DEPTH) (min 1) / DATA_W / 1  beat tag, payload, RLAST
- rsp_valid / rsp_ready  out/in  1  completion handshake
- rsp_slot / rsp_resp / rsp_lenerr  out  log2 / `AXI_RESP_W / 1  completion status
- ost_cnt  out  log2(OST_DEPTH)+1  slots not FREE
- err_unexp  out  1  pulse: R beat whose RID does not match a slot in OST

## Operation
- Per-slot state: FREE → PEND (cmd accepted) → OST (AR handshake) → DONE (RLAST received) → FREE (rsp handshake).
- Three wrap-around pointers: alloc (next slot to fill), req (next AR), head (next rsp). All advance by +1 modulo OST_DEPTH.
- cmd_ready = (slot[alloc] == FREE), computed from registered state only. Commands are accepted in order into consecutive slots.
- AR: arvalid = (slot[req] == PEND). Payload comes from the slot registers. ARID = slot index, zero-extended to ID_W. Payload is held stable until arready.
- R: rready tied to 1. Slot is selected by RID[log2-1:0]. Upper RID bits that are non-zero, or a slot not in OST, raise err_unexp; the beat is consumed with no state change and no dat_valid.
- Valid beat:
  - dat_* mirror the beat.
  - Slot beat counter (LEN_W+1 bits, cleared on alloc) increments.
  - Slot resp = max(resp, rresp), numeric max, so DECERR > SLVERR > EXOKAY > OKAY.
- lenerr is set if rlast arrives with count ≠ cmd_len, or if count reaches cmd_len+1 without rlast. In the second case further beats keep counting and saturate.
- rlast on a valid beat moves the slot to DONE.
- rsp_valid = (slot[head] == DONE). rsp_* come from slot[head]. Out-of-order RLASTs wait behind head.
- Simultaneous events in one cycle are all legal: cmd accept, AR handshake, R beat and rsp handshake on four different slots. A slot cannot be hit by two of them in the same cycle by construction.

## Timing
- Reset values: cmd_ready=1, arvalid=0, all AR payload 0, rready=1, dat_valid=0, rsp_valid=0, ost_cnt=0, err_unexp=0. All slots FREE, all pointers 0.
- Reset mid-operation discards every slot immediately. The bench must not rely on any in-flight R traffic after rst.
- cmd accept at cycle N → arvalid at N+1 at earliest.
- AR handshake at N → slot OST at N+1; an R beat for it is accepted from N+1.
- dat_* are registered: R beat at N → dat_valid at N+1.
- rlast at N → rsp_valid at N+1 at earliest, if the slot is head.
- rsp handshake at N → cmd_ready for that slot at N+1. Full-pool turnaround costs 1 cycle.
- err_unexp is a registered pulse, asserted at N+1.

## Structure
- Shared package `easyaxi_pkg`: slot state enum (FREE/PEND/OST/DONE), AXI size/burst/resp constants, a resp-merge function.
- One sub-module, `easyaxi_rd_slot`: per-slot state, descriptor, beat counter, resp merge, lenerr. Instantiated OST_DEPTH times.
- The top holds the pointers, muxes, the ost_cnt counter and the dat/err registers.

## Test plan
- Single INCR burst: addr 0x100, len 3, size 4B → ARID 0, ARLEN 3, 4 dat pulses tagged slot 0, rsp resp OKAY, lenerr 0.
- Fill OST_DEPTH=8 with arready=1 and no R → cmd_ready low after the 8th command, ost_cnt=8. The 9th command is accepted one cycle after the first rsp handshake.
- Out-of-order RLAST: slots 1 and 2 complete before slot 0 → no rsp until slot 0 completes, then rsp slots 0, 1, 2 on consecutive cycles with rsp_ready=1.
- Resp merge: beats OKAY, SLVERR, OKAY, EXOKAY → rsp_resp SLVERR. Beats OKAY, DECERR → DECERR.
- Length errors: len 3 with rlast on beat 2 → lenerr 1, slot DONE. len 1 with 3 beats, rlast on the 3rd → lenerr 1.
- Unexpected RID 5 while slot 5 is FREE → err_unexp pulse, no dat_valid, ost_cnt unchanged. Assert rst during an active burst → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/easyaxi_pkg.sv
// Shared EasyAXI definitions: AXI channel widths and encodings, read-slot state
// encoding and the response-merge helper.
package easyaxi_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_1B = 3'd0;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_2B = 3'd1;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_4B = 3'd2;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_8B = 3'd3;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_OST  = 2'd2,
    SLOT_DONE = 2'd3
  } slot_state_e;

  // The numeric order of the encodings is also their severity order.
  function automatic logic [AXI_RESP_W-1:0] resp_merge(input logic [AXI_RESP_W-1:0] acc,
                                                        input logic [AXI_RESP_W-1:0] nxt);
    return (nxt > acc) ? nxt : acc;
  endfunction

endpackage

// File: rtl/easyaxi_rd_slot.sv
// One read tracking slot: lifecycle state, burst descriptor, beat counter,
// merged response and length-error flag.
module easyaxi_rd_slot
  import easyaxi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int LEN_W  = AXI_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc,
  input  logic [ADDR_W-1:0]      alloc_addr,
  input  logic [LEN_W-1:0]       alloc_len,
  input  logic [AXI_SIZE_W-1:0]  alloc_size,
  input  logic [AXI_BURST_W-1:0] alloc_burst,
  input  logic                   ar_hs,
  input  logic                   beat,
  input  logic [AXI_RESP_W-1:0]  beat_resp,
  input  logic                   beat_last,
  input  logic                   rsp_hs,
  output logic [1:0]             state,
  output logic [ADDR_W-1:0]      addr,
  output logic [LEN_W-1:0]       len,
  output logic [AXI_SIZE_W-1:0]  size,
  output logic [AXI_BURST_W-1:0] burst,
  output logic [AXI_RESP_W-1:0]  resp,
  output logic                   lenerr
);

  localparam logic [LEN_W:0] CNT_MAX = '1;

  slot_state_e            state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [AXI_SIZE_W-1:0]  size_q, size_d;
  logic [AXI_BURST_W-1:0] burst_q, burst_d;
  logic [LEN_W:0]         cnt_q, cnt_d;
  logic [AXI_RESP_W-1:0]  resp_q, resp_d;
  logic                   lenerr_q, lenerr_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    resp_d   = resp_q;
    lenerr_d = lenerr_q;
    case (state_q)
      SLOT_FREE: if (alloc) begin
        state_d  = SLOT_PEND;
        addr_d   = alloc_addr;
        len_d    = alloc_len;
        size_d   = alloc_size;
        burst_d  = alloc_burst;
        cnt_d    = '0;
        resp_d   = AXI_RESP_OKAY;
        lenerr_d = 1'b0;
      end
      SLOT_PEND: if (ar_hs) state_d = SLOT_OST;
      SLOT_OST: if (beat) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        resp_d = resp_merge(resp_q, beat_resp);
        // cnt_q counts beats before this one: last must land on index len,
        // and a non-last beat at index len overruns the burst.
        if (beat_last ? (cnt_q != {1'b0, len_q}) : (cnt_q == {1'b0, len_q}))
          lenerr_d = 1'b1;
        if (beat_last) state_d = SLOT_DONE;
      end
      SLOT_DONE: if (rsp_hs) state_d = SLOT_FREE;
      default: state_d = SLOT_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SLOT_FREE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    len_q    <= len_d;
    size_q   <= size_d;
    burst_q  <= burst_d;
    cnt_q    <= cnt_d;
    resp_q   <= resp_d;
    lenerr_q <= lenerr_d;
  end

  assign state  = state_q;
  assign addr   = addr_q;
  assign len    = len_q;
  assign size   = size_q;
  assign burst  = burst_q;
  assign resp   = resp_q;
  assign lenerr = lenerr_q;

endmodule

// File: rtl/easyaxi_rd_mst.sv
// AXI read master: in-order command slots, AR issue, RID-tagged beat forwarding
// and in-order completion status.
module easyaxi_rd_mst
  import easyaxi_pkg::*;
#(
  parameter int OST_DEPTH = 8,
  parameter int ID_W      = AXI_ID_W,
  parameter int ADDR_W    = AXI_ADDR_W,
  parameter int DATA_W    = AXI_DATA_W,
  parameter int LEN_W     = AXI_LEN_W,
  localparam int SLOT_W   = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1,
  localparam int CNT_W    = $clog2(OST_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic [AXI_SIZE_W-1:0]  cmd_size,
  input  logic [AXI_BURST_W-1:0] cmd_burst,
  output logic                   axi_mst_arvalid,
  input  logic                   axi_mst_arready,
  output logic [ID_W-1:0]        axi_mst_arid,
  output logic [ADDR_W-1:0]      axi_mst_araddr,
  output logic [LEN_W-1:0]       axi_mst_arlen,
  output logic [AXI_SIZE_W-1:0]  axi_mst_arsize,
  output logic [AXI_BURST_W-1:0] axi_mst_arburst,
  input  logic                   axi_mst_rvalid,
  output logic                   axi_mst_rready,
  input  logic [ID_W-1:0]        axi_mst_rid,
  input  logic [DATA_W-1:0]      axi_mst_rdata,
  input  logic [AXI_RESP_W-1:0]  axi_mst_rresp,
  input  logic                   axi_mst_rlast,
  output logic                   dat_valid,
  output logic [SLOT_W-1:0]      dat_slot,
  output logic [DATA_W-1:0]      dat_data,
  output logic                   dat_last,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [SLOT_W-1:0]      rsp_slot,
  output logic [AXI_RESP_W-1:0]  rsp_resp,
  output logic                   rsp_lenerr,
  output logic [CNT_W-1:0]       ost_cnt,
  output logic                   err_unexp
);

  localparam logic [ID_W-1:0] MAX_ID = ID_W'(OST_DEPTH - 1);

  function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
    return (p == SLOT_W'(OST_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [1:0]             slot_state [OST_DEPTH];
  logic [ADDR_W-1:0]      slot_addr  [OST_DEPTH];
  logic [LEN_W-1:0]       slot_len   [OST_DEPTH];
  logic [AXI_SIZE_W-1:0]  slot_size  [OST_DEPTH];
  logic [AXI_BURST_W-1:0] slot_burst [OST_DEPTH];
  logic [AXI_RESP_W-1:0]  slot_resp  [OST_DEPTH];
  logic                   slot_lenerr[OST_DEPTH];

  logic [SLOT_W-1:0] alloc_q, alloc_d, req_q, req_d, head_q, head_d;
  logic [CNT_W-1:0]  ost_cnt_q, ost_cnt_d;
  logic              dat_valid_q, dat_valid_d, err_unexp_q, err_unexp_d;
  logic [SLOT_W-1:0] dat_slot_q, dat_slot_d;
  logic [DATA_W-1:0] dat_data_q, dat_data_d;
  logic              dat_last_q, dat_last_d;

  logic              cmd_hs, ar_hs, rsp_hs, rid_in_range, beat_ok;
  logic [SLOT_W-1:0] rid_slot;

  assign cmd_ready       = (slot_state[alloc_q] == SLOT_FREE);
  assign axi_mst_arvalid = (slot_state[req_q] == SLOT_PEND);
  assign rsp_valid       = (slot_state[head_q] == SLOT_DONE);
  assign axi_mst_rready  = 1'b1;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign ar_hs  = axi_mst_arvalid && axi_mst_arready;
  assign rsp_hs = rsp_valid && rsp_ready;

  // A beat is only trusted when its RID names a slot that is waiting for data.
  assign rid_slot     = axi_mst_rid[SLOT_W-1:0];
  assign rid_in_range = (axi_mst_rid <= MAX_ID);
  assign beat_ok      = axi_mst_rvalid && rid_in_range && (slot_state[rid_slot] == SLOT_OST);

  // Payload is zeroed while idle so the bus shows a clean value after reset.
  assign axi_mst_arid    = axi_mst_arvalid ? ID_W'(req_q)       : '0;
  assign axi_mst_araddr  = axi_mst_arvalid ? slot_addr[req_q]  : '0;
  assign axi_mst_arlen   = axi_mst_arvalid ? slot_len[req_q]   : '0;
  assign axi_mst_arsize  = axi_mst_arvalid ? slot_size[req_q]  : '0;
  assign axi_mst_arburst = axi_mst_arvalid ? slot_burst[req_q] : '0;

  assign rsp_slot   = head_q;
  assign rsp_resp   = slot_resp[head_q];
  assign rsp_lenerr = slot_lenerr[head_q];

  for (genvar i = 0; i < OST_DEPTH; i++) begin : g_slot
    easyaxi_rd_slot #(
      .ADDR_W(ADDR_W),
      .LEN_W (LEN_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .alloc      (cmd_hs && (alloc_q == SLOT_W'(i))),
      .alloc_addr (cmd_addr),
      .alloc_len  (cmd_len),
      .alloc_size (cmd_size),
      .alloc_burst(cmd_burst),
      .ar_hs      (ar_hs && (req_q == SLOT_W'(i))),
      .beat       (beat_ok && (rid_slot == SLOT_W'(i))),
      .beat_resp  (axi_mst_rresp),
      .beat_last  (axi_mst_rlast),
      .rsp_hs     (rsp_hs && (head_q == SLOT_W'(i))),
      .state      (slot_state[i]),
      .addr       (slot_addr[i]),
      .len        (slot_len[i]),
      .size       (slot_size[i]),
      .burst      (slot_burst[i]),
      .resp       (slot_resp[i]),
      .lenerr     (slot_lenerr[i])
    );
  end

  always_comb begin
    alloc_d     = cmd_hs ? ptr_inc(alloc_q) : alloc_q;
    req_d       = ar_hs  ? ptr_inc(req_q)   : req_q;
    head_d      = rsp_hs ? ptr_inc(head_q)  : head_q;
    ost_cnt_d   = ost_cnt_q;
    if (cmd_hs && !rsp_hs)      ost_cnt_d = ost_cnt_q + 1'b1;
    else if (!cmd_hs && rsp_hs) ost_cnt_d = ost_cnt_q - 1'b1;
    dat_valid_d = beat_ok;
    err_unexp_d = axi_mst_rvalid && !beat_ok;
    dat_slot_d  = beat_ok ? rid_slot      : dat_slot_q;
    dat_data_d  = beat_ok ? axi_mst_rdata : dat_data_q;
    dat_last_d  = beat_ok ? axi_mst_rlast : dat_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q     <= '0;
      req_q       <= '0;
      head_q      <= '0;
      ost_cnt_q   <= '0;
      dat_valid_q <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      alloc_q     <= alloc_d;
      req_q       <= req_d;
      head_q      <= head_d;
      ost_cnt_q   <= ost_cnt_d;
      dat_valid_q <= dat_valid_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  always_ff @(posedge clk) begin
    dat_slot_q <= dat_slot_d;
    dat_data_q <= dat_data_d;
    dat_last_q <= dat_last_d;
  end

  assign ost_cnt   = ost_cnt_q;
  assign dat_valid = dat_valid_q;
  assign dat_slot  = dat_slot_q;
  assign dat_data  = dat_data_q;
  assign dat_last  = dat_last_q;
  assign err_unexp = err_unexp_q;

endmodule

// File: tb/tb_easyaxi_rd_mst.sv
// Directed bench for easyaxi_rd_mst: table of single bursts plus hand-written
// fill, out-of-order, unexpected-RID and reset sequences.
module tb_easyaxi_rd_mst;
  import easyaxi_pkg::*;

  localparam int OST    = 8;
  localparam int ID_W   = AXI_ID_W;
  localparam int ADDR_W = AXI_ADDR_W;
  localparam int DATA_W = AXI_DATA_W;
  localparam int LEN_W  = AXI_LEN_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid, cmd_ready;
  logic [ADDR_W-1:0]      cmd_addr;
  logic [LEN_W-1:0]       cmd_len;
  logic [AXI_SIZE_W-1:0]  cmd_size;
  logic [AXI_BURST_W-1:0] cmd_burst;
  logic                   arvalid, arready;
  logic [ID_W-1:0]        arid;
  logic [ADDR_W-1:0]      araddr;
  logic [LEN_W-1:0]       arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;
  logic                   rvalid, rready;
  logic [ID_W-1:0]        rid;
  logic [DATA_W-1:0]      rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast;
  logic                   dat_valid, dat_last;
  logic [2:0]             dat_slot;
  logic [DATA_W-1:0]      dat_data;
  logic                   rsp_valid, rsp_ready, rsp_lenerr;
  logic [2:0]             rsp_slot;
  logic [AXI_RESP_W-1:0]  rsp_resp;
  logic [3:0]             ost_cnt;
  logic                   err_unexp;

  int checks = 0;
  int errors = 0;
  int dat_cnt = 0;
  int dat_last_cnt = 0;
  logic [2:0]        mon_slot;
  logic [DATA_W-1:0] mon_data;

  easyaxi_rd_mst #(.OST_DEPTH(OST)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .axi_mst_arvalid(arvalid), .axi_mst_arready(arready), .axi_mst_arid(arid),
    .axi_mst_araddr(araddr), .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
    .axi_mst_arburst(arburst),
    .axi_mst_rvalid(rvalid), .axi_mst_rready(rready), .axi_mst_rid(rid),
    .axi_mst_rdata(rdata), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast),
    .dat_valid(dat_valid), .dat_slot(dat_slot), .dat_data(dat_data), .dat_last(dat_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_slot(rsp_slot), .rsp_resp(rsp_resp),
    .rsp_lenerr(rsp_lenerr), .ost_cnt(ost_cnt), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dat_valid) begin
      dat_cnt  = dat_cnt + 1;
      mon_slot = dat_slot;
      mon_data = dat_data;
      if (dat_last) dat_last_cnt = dat_last_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timed_out(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no event within budget, required event", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    cmd_size = AXI_SIZE_4B; cmd_burst = AXI_BURST_INCR;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) timed_out("cmd_accept");
    else tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ar(input int id, input logic [LEN_W-1:0] l, input logic [ADDR_W-1:0] a);
    int n = 0;
    while (!arvalid && n < 50) begin tick(); n++; end
    if (!arvalid) timed_out("ar_valid");
    else begin
      chk("arid", 64'(arid), 64'(id));
      chk("arlen", 64'(arlen), 64'(l));
      chk("araddr", 64'(araddr), 64'(a));
      chk("arsize", 64'(arsize), 64'(AXI_SIZE_4B));
      chk("arburst", 64'(arburst), 64'(AXI_BURST_INCR));
      tick();
    end
  endtask

  task automatic r_beat(input int id, input logic [DATA_W-1:0] d,
                        input logic [AXI_RESP_W-1:0] rs, input logic lst);
    rvalid = 1'b1; rid = ID_W'(id); rdata = d; rresp = rs; rlast = lst;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic get_rsp(input string nm, input int slot,
                         input logic [AXI_RESP_W-1:0] rs, input logic le);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    if (!rsp_valid) timed_out({nm, "_rsp"});
    else begin
      chk({nm, "_rsp_slot"}, 64'(rsp_slot), 64'(slot));
      chk({nm, "_rsp_resp"}, 64'(rsp_resp), 64'(rs));
      chk({nm, "_rsp_lenerr"}, 64'(rsp_lenerr), 64'(le));
      tick();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    chk({tag, "_arvalid"}, 64'(arvalid), 64'(0));
    chk({tag, "_arid"}, 64'(arid), 64'(0));
    chk({tag, "_araddr"}, 64'(araddr), 64'(0));
    chk({tag, "_arlen"}, 64'(arlen), 64'(0));
    chk({tag, "_rready"}, 64'(rready), 64'(1));
    chk({tag, "_dat_valid"}, 64'(dat_valid), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_ost_cnt"}, 64'(ost_cnt), 64'(0));
    chk({tag, "_err_unexp"}, 64'(err_unexp), 64'(0));
  endtask

  typedef struct {
    logic [LEN_W-1:0]      len;
    int                    nbeats;
    logic [7:0]            resps;     // 2 bits per beat, beat 0 in [1:0]
    logic [AXI_RESP_W-1:0] exp_resp;
    logic                  exp_lenerr;
  } vec_t;

  vec_t vecs[6];
  int b0, l0;
  logic [ADDR_W-1:0] va;
  logic [DATA_W-1:0] vd;

  initial begin
    vecs[0] = '{8'd3, 4, 8'h00, AXI_RESP_OKAY,   1'b0};
    vecs[1] = '{8'd3, 4, 8'h48, AXI_RESP_SLVERR, 1'b0};
    vecs[2] = '{8'd1, 2, 8'h0C, AXI_RESP_DECERR, 1'b0};
    vecs[3] = '{8'd3, 2, 8'h00, AXI_RESP_OKAY,   1'b1};
    vecs[4] = '{8'd1, 3, 8'h00, AXI_RESP_OKAY,   1'b1};
    vecs[5] = '{8'd0, 1, 8'h01, AXI_RESP_EXOKAY, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    arready = 1'b1; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    rsp_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    check_rst("init");

    // Table of single bursts; slot i carries vector i.
    vd = '0;
    for (int i = 0; i < 6; i++) begin
      b0 = dat_cnt; l0 = dat_last_cnt;
      va = 32'h100 + ADDR_W'(i) * 32'h40;
      send_cmd(va, vecs[i].len);
      wait_ar(i, vecs[i].len, va);
      for (int k = 0; k < vecs[i].nbeats; k++) begin
        vd = 32'hA000_0000 | (DATA_W'(i) << 8) | DATA_W'(k);
        r_beat(i, vd, vecs[i].resps[2*k +: 2], (k == vecs[i].nbeats - 1));
      end
      get_rsp($sformatf("vec%0d", i), i, vecs[i].exp_resp, vecs[i].exp_lenerr);
      chk($sformatf("vec%0d_dat_cnt", i), 64'(dat_cnt - b0), 64'(vecs[i].nbeats));
      chk($sformatf("vec%0d_dat_last", i), 64'(dat_last_cnt - l0), 64'(1));
      chk($sformatf("vec%0d_dat_slot", i), 64'(mon_slot), 64'(i));
      chk($sformatf("vec%0d_dat_data", i), 64'(mon_data), 64'(vd));
    end

    // Fill all slots with no R traffic, then recycle slot 0.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < OST; i++) send_cmd(32'h1000 + ADDR_W'(i) * 32'h10, 8'd0);
    chk("fill_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("fill_ost_cnt", 64'(ost_cnt), 64'(8));
    cmd_valid = 1'b1; cmd_addr = 32'h2000; cmd_len = 8'd0;
    tick(); tick();
    chk("fill_blocked", 64'(cmd_ready), 64'(0));
    r_beat(0, 32'h1234_5678, AXI_RESP_OKAY, 1'b1);
    chk("fill_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("fill_rsp_slot", 64'(rsp_slot), 64'(0));
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("fill_ready_after_rsp", 64'(cmd_ready), 64'(1));
    chk("fill_ost_after_rsp", 64'(ost_cnt), 64'(7));
    tick();
    cmd_valid = 1'b0;
    chk("fill_9th_ost", 64'(ost_cnt), 64'(8));
    chk("fill_9th_ready", 64'(cmd_ready), 64'(0));
    chk("fill_9th_arvalid", 64'(arvalid), 64'(1));
    chk("fill_9th_arid", 64'(arid), 64'(0));
    chk("fill_9th_araddr", 64'(araddr), 64'(32'h2000));

    // Out-of-order RLAST: slots 1 and 2 finish before slot 0.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) send_cmd(32'h3000 + ADDR_W'(i) * 32'h100, 8'd0);
    tick(); tick();
    r_beat(1, 32'h11, AXI_RESP_OKAY, 1'b1);
    chk("ooo_hold_a", 64'(rsp_valid), 64'(0));
    r_beat(2, 32'h22, AXI_RESP_SLVERR, 1'b1);
    chk("ooo_hold_b", 64'(rsp_valid), 64'(0));
    tick();
    chk("ooo_hold_c", 64'(rsp_valid), 64'(0));
    r_beat(0, 32'h00, AXI_RESP_OKAY, 1'b1);
    chk("ooo_r0_valid", 64'(rsp_valid), 64'(1));
    chk("ooo_r0_slot", 64'(rsp_slot), 64'(0));
    rsp_ready = 1'b1; tick();
    chk("ooo_r1_valid", 64'(rsp_valid), 64'(1));
    chk("ooo_r1_slot", 64'(rsp_slot), 64'(1));
    tick();
    chk("ooo_r2_valid", 64'(rsp_valid), 64'(1));
    chk("ooo_r2_slot", 64'(rsp_slot), 64'(2));
    chk("ooo_r2_resp", 64'(rsp_resp), 64'(AXI_RESP_SLVERR));
    tick();
    rsp_ready = 1'b0;
    chk("ooo_drained", 64'(rsp_valid), 64'(0));
    chk("ooo_ost_cnt", 64'(ost_cnt), 64'(0));

    // Unexpected RID 5 while slot 5 is FREE and slot 3 is outstanding.
    send_cmd(32'h4000, 8'd3);
    tick();
    b0 = dat_cnt;
    r_beat(5, 32'hDEAD_BEEF, AXI_RESP_OKAY, 1'b0);
    chk("unexp_err", 64'(err_unexp), 64'(1));
    chk("unexp_dat_valid", 64'(dat_valid), 64'(0));
    chk("unexp_ost_cnt", 64'(ost_cnt), 64'(1));
    tick();
    chk("unexp_err_pulse", 64'(err_unexp), 64'(0));
    chk("unexp_dat_cnt", 64'(dat_cnt - b0), 64'(0));

    // Reset in the middle of slot 3's burst with slot 4 waiting on AR.
    r_beat(3, 32'h3333_0000, AXI_RESP_OKAY, 1'b0);
    chk("mid_dat_valid", 64'(dat_valid), 64'(1));
    arready = 1'b0;
    send_cmd(32'h5000, 8'd0);
    chk("mid_arvalid", 64'(arvalid), 64'(1));
    chk("mid_arid", 64'(arid), 64'(4));
    chk("mid_ost_cnt", 64'(ost_cnt), 64'(2));
    rst = 1'b1; tick(); rst = 1'b0;
    check_rst("midrst");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

endmodule
